// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// csa_pkg : state encoding and width helpers for the carry-save accumulator
// Revision: 1.0
// ============================================================================
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } csa_state_e;

    function automatic int csa_len_w(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

    // Growth of LEN_W bits covers MAX_OPS unsigned additions without overflow
    function automatic int csa_out_w(input int width, input int max_ops);
        return width + csa_len_w(max_ops);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// csa_row : combinational N-bit 3:2 compressor, one full adder per bit
// Revision: 1.0
// ============================================================================
module csa_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] c_o
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i] = x_i[i] ^ y_i[i] ^ z_i[i];
        assign c_o[i] = (x_i[i] & y_i[i]) | (x_i[i] & z_i[i]) | (y_i[i] & z_i[i]);
    end

endmodule
`default_nettype wire

// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
// csa_accumulator : sequential multi-operand add/sub accumulator holding the
//                   running total in sum/carry form, resolved by one final add
// Revision: 1.0
// ============================================================================
module csa_accumulator
    import csa_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int MAX_OPS = 15,
    parameter  int SIGNED  = 0,
    localparam int LEN_W   = csa_len_w(MAX_OPS),
    localparam int OUT_W   = csa_out_w(WIDTH, MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic             busy
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_OPS);

    csa_state_e       state_q;
    logic [OUT_W-1:0] s_q;
    logic [OUT_W-1:0] c_q;
    logic [LEN_W-1:0] rem_q;
    logic [OUT_W-1:0] sum_q;

    logic [OUT_W-1:0] w_x;
    logic [OUT_W-1:0] w_xp;
    logic [OUT_W-1:0] w_row_c;
    logic [OUT_W-1:0] s_d;
    logic [OUT_W-1:0] c_d;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_accept;

    if (SIGNED != 0) begin : g_signed
        assign w_x = {{LEN_W{in_data[WIDTH-1]}}, in_data};
    end else begin : g_unsigned
        assign w_x = {{LEN_W{1'b0}}, in_data};
    end

    assign w_xp = in_sub ? ~w_x : w_x;

    csa_row #(
        .N (OUT_W)
    ) u_row (
        .x_i (s_q),
        .y_i (c_q),
        .z_i (w_xp),
        .s_o (s_d),
        .c_o (w_row_c)
    );

    // Shift frees the carry LSB, which takes the +1 completing ~X for subtract
    assign c_d = (w_row_c << 1) | {{(OUT_W-1){1'b0}}, in_sub};

    assign w_len_clamped = (len > C_MAX_LEN) ? C_MAX_LEN : len;
    assign w_accept      = in_valid && (state_q == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        s_q   <= '0;
                        c_q   <= '0;
                        rem_q <= w_len_clamped;
                        state_q <= (len == '0) ? ST_RESOLVE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    sum_q   <= s_q + c_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulator.sv
`default_nettype none
// ============================================================================
// tb_csa_accumulator : directed vectors against hand-computed results
// Revision: 1.0
// ============================================================================
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] op_d [0:19];
    logic        op_s [0:19];

    csa_accumulator #(
        .WIDTH   (16),
        .MAX_OPS (15),
        .SIGNED  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = 4'hF;
    endtask

    // Feeds n operands from op_d/op_s; optional idle gaps carry junk data
    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                in_sub   = 1'b1;
                step();
            end
            in_valid = 1'b1;
            in_data  = op_d[i];
            in_sub   = op_s[i];
            chk($sformatf("in_ready_op%0d", i), {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
        in_sub   = 1'b0;
    endtask

    // Called one cycle after the last accept: RESOLVE, then result next cycle
    task automatic check_result(input string tag, input logic [19:0] exp);
        chk({tag, "_resolve_ov"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_resolve_ir"}, {31'd0, in_ready}, 32'd0);
        step();
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"}, {12'd0, out_sum}, {12'd0, exp});
    endtask

    task automatic finish_hs(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
        in_data = 16'h0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ir", {31'd0, in_ready}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {12'd0, out_sum}, 32'd0);
        rst = 1'b0;
        step();

        // Basic add 1+2+3
        op_d[0] = 16'h0001; op_s[0] = 1'b0;
        op_d[1] = 16'h0002; op_s[1] = 1'b0;
        op_d[2] = 16'h0003; op_s[2] = 1'b0;
        do_start(4'd3);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        feed(3, 1'b0);
        check_result("basic", 20'h00006);
        finish_hs("basic");

        // Fifteen maximum operands, then len=20 is clamped to 15
        for (int i = 0; i < 15; i++) begin
            op_d[i] = 16'hFFFF;
            op_s[i] = 1'b0;
        end
        do_start(4'd15);
        feed(15, 1'b0);
        check_result("max", 20'hEFFF1);
        finish_hs("max");

        start = 1'b1;
        len   = 4'd15;
        begin
            logic [4:0] big;
            big = 5'd20;
            len = (big > 5'd15) ? 4'd15 : big[3:0];
        end
        step();
        start = 1'b0;
        feed(15, 1'b0);
        check_result("clamp", 20'hEFFF1);
        finish_hs("clamp");

        // 100 - 30
        op_d[0] = 16'd100; op_s[0] = 1'b0;
        op_d[1] = 16'd30;  op_s[1] = 1'b1;
        do_start(4'd2);
        feed(2, 1'b0);
        check_result("sub", 20'h00046);
        finish_hs("sub");

        // 0 - 1 wraps to all ones
        op_d[0] = 16'd1; op_s[0] = 1'b1;
        do_start(4'd1);
        feed(1, 1'b0);
        check_result("neg", 20'hFFFFF);
        finish_hs("neg");

        // Zero length: straight to RESOLVE, in_ready never raised
        do_start(4'd0);
        check_result("zero", 20'h00000);
        finish_hs("zero");

        // Gapped input stream, junk on data/sub while in_valid is low
        op_d[0] = 16'd5;  op_s[0] = 1'b0;
        op_d[1] = 16'd7;  op_s[1] = 1'b0;
        op_d[2] = 16'd9;  op_s[2] = 1'b0;
        op_d[3] = 16'd11; op_s[3] = 1'b0;
        do_start(4'd4);
        feed(4, 1'b1);
        check_result("gaps", 20'h00020);

        // Backpressure: hold result for 5 cycles while start is asserted
        start = 1'b1;
        len   = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_ov%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_sum%0d", i), {12'd0, out_sum}, 32'h20);
        end
        start = 1'b0;
        finish_hs("bp");
        op_d[0] = 16'h0010; op_s[0] = 1'b0;
        do_start(4'd1);
        chk("bp_next_ir", {31'd0, in_ready}, 32'd1);
        feed(1, 1'b0);
        check_result("bp_next", 20'h00010);
        finish_hs("bp_next");

        // Reset after 2 of 4 operands
        op_d[0] = 16'h1111; op_s[0] = 1'b0;
        op_d[1] = 16'h2222; op_s[1] = 1'b0;
        do_start(4'd4);
        feed(2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ir", {31'd0, in_ready}, 32'd0);
        chk("mrst_ov", {31'd0, out_valid}, 32'd0);
        chk("mrst_sum", {12'd0, out_sum}, 32'd0);
        step();
        chk("mrst_hold_ov", {31'd0, out_valid}, 32'd0);
        op_d[0] = 16'h1234; op_s[0] = 1'b0;
        do_start(4'd1);
        feed(1, 1'b0);
        check_result("post_rst", 20'h01234);
        finish_hs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
